brush_painter: RTL and testbench

BRUSH_PAINTER -- requirements
Module: brush_painter

---
 rtl/paint_pkg.sv | 23 ++
 rtl/scan_counter_2d.sv | 51 +++++
 rtl/brush_painter.sv | 146 ++++++++++++++
 tb/tb_brush_painter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared types and widths for the brush painter.
// Holds the FSM state enum and the coordinate/pixel widths.
package paint_pkg;

    localparam int CW = 11;
    localparam int PW = 8;

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        CLEAR
    } state_t;

    function automatic logic in_bounds(
        input logic [CW:0] px,
        input logic [CW:0] py,
        input int          w,
        input int          h
    );
        return (px < (CW+1)'(w)) && (py < (CW+1)'(h));
    endfunction

endpackage

// File: rtl/scan_counter_2d.sv
// Row-major 2-D scan counter with runtime limits and a last flag.
// Start acts as a step taken from the origin; the caller emits (0,0) itself.
module scan_counter_2d
    import paint_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_start,
    input  logic          i_step,
    input  logic [CW-1:0] i_lim_w,
    input  logic [CW-1:0] i_lim_h,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_last,
    output logic          o_single
);

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] w_bx;
    logic [CW-1:0] w_by;
    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;

    always_comb begin
        w_bx = i_start ? '0 : r_x;
        w_by = i_start ? '0 : r_y;
        w_nx = w_bx + 1'b1;
        w_ny = w_by;
        if (w_bx == i_lim_w - 1'b1) begin
            w_nx = '0;
            w_ny = w_by + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_start || i_step) begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_last   = (r_x == i_lim_w - 1'b1) && (r_y == i_lim_h - 1'b1);
    assign o_single = (i_lim_w == CW'(1)) && (i_lim_h == CW'(1));

endmodule

// File: rtl/brush_painter.sv
// Square-brush framebuffer painter with full-screen clear.
// One pixel write per cycle; outputs are registered.
module brush_painter
    import paint_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int BRUSH    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          clr,
    input  logic          middle,
    input  logic [CW-1:0] mouse_x,
    input  logic [CW-1:0] mouse_y,
    input  logic [PW-1:0] gray,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [PW-1:0] pixel_GS,
    output logic          pixel_write,
    output logic          busy
);

    localparam logic [CW-1:0] LIM_SW = CW'(SCREEN_W);
    localparam logic [CW-1:0] LIM_SH = CW'(SCREEN_H);
    localparam logic [CW-1:0] LIM_B  = CW'(BRUSH);

    state_t        r_state;
    logic          r_clr_pending;
    logic          r_last_valid;
    logic [CW-1:0] r_bx;
    logic [CW-1:0] r_by;
    logic [PW-1:0] r_color;

    logic [CW-1:0] w_cx;
    logic [CW-1:0] w_cy;
    logic          w_last;
    logic          w_single;
    logic [PW-1:0] w_color;
    logic          w_repeat;
    logic          w_go_clr;
    logic          w_go_paint;
    logic          w_start;
    logic          w_step;
    logic          w_use_screen;
    logic [CW-1:0] w_lim_w;
    logic [CW-1:0] w_lim_h;
    logic [CW:0]   w_px;
    logic [CW:0]   w_py;

    assign w_color    = middle ? '0 : gray;
    assign w_repeat   = r_last_valid && (mouse_x == r_bx) &&
                        (mouse_y == r_by) && (w_color == r_color);
    assign w_go_clr   = (r_state == IDLE) && (r_clr_pending || clr);
    assign w_go_paint = (r_state == IDLE) && !w_go_clr &&
                        enable && !w_repeat;
    assign w_start    = w_go_clr || w_go_paint;
    assign w_step     = (r_state != IDLE) && !w_last;

    assign w_use_screen = (r_state == CLEAR) || w_go_clr;
    assign w_lim_w      = w_use_screen ? LIM_SW : LIM_B;
    assign w_lim_h      = w_use_screen ? LIM_SH : LIM_B;

    // 12-bit sums so a brush hanging off the edge clips instead of wrapping
    assign w_px = {1'b0, r_bx} + {1'b0, w_cx};
    assign w_py = {1'b0, r_by} + {1'b0, w_cy};

    scan_counter_2d u_scan (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_lim_w  (w_lim_w),
        .i_lim_h  (w_lim_h),
        .o_x      (w_cx),
        .o_y      (w_cy),
        .o_last   (w_last),
        .o_single (w_single)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_clr_pending <= 1'b0;
            r_last_valid  <= 1'b0;
            r_bx          <= '0;
            r_by          <= '0;
            r_color       <= '0;
            x             <= '0;
            y             <= '0;
            pixel_GS      <= '0;
            pixel_write   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (clr) r_clr_pending <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    pixel_write <= 1'b0;
                    busy        <= 1'b0;
                    if (w_go_clr) begin
                        r_clr_pending <= 1'b0;
                        r_last_valid  <= 1'b0;
                        x             <= '0;
                        y             <= '0;
                        pixel_GS      <= '0;
                        pixel_write   <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= w_single ? IDLE : CLEAR;
                    end else if (w_go_paint) begin
                        r_bx         <= mouse_x;
                        r_by         <= mouse_y;
                        r_color      <= w_color;
                        r_last_valid <= 1'b1;
                        x            <= mouse_x;
                        y            <= mouse_y;
                        pixel_GS     <= w_color;
                        pixel_write  <= in_bounds({1'b0, mouse_x},
                                                  {1'b0, mouse_y},
                                                  SCREEN_W, SCREEN_H);
                        busy         <= 1'b1;
                        r_state      <= w_single ? IDLE : PAINT;
                    end
                end
                PAINT: begin
                    x           <= w_px[CW-1:0];
                    y           <= w_py[CW-1:0];
                    pixel_GS    <= r_color;
                    pixel_write <= in_bounds(w_px, w_py, SCREEN_W, SCREEN_H);
                    busy        <= 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                CLEAR: begin
                    x           <= w_cx;
                    y           <= w_cy;
                    pixel_GS    <= '0;
                    pixel_write <= 1'b1;
                    busy        <= 1'b1;
                    if (w_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brush_painter.sv
// Scoreboard bench for brush_painter on a reduced 128x64 screen.
module tb_brush_painter;

    localparam int SW = 128;
    localparam int SH = 64;
    localparam int BR = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        clr     = 1'b0;
    logic        middle  = 1'b0;
    logic [10:0] mouse_x = '0;
    logic [10:0] mouse_y = '0;
    logic [7:0]  gray    = '0;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  pixel_GS;
    logic        pixel_write;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    int wr_cnt   = 0;
    int snap;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    brush_painter #(
        .SCREEN_W (SW),
        .SCREEN_H (SH),
        .BRUSH    (BR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clr         (clr),
        .middle      (middle),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .gray        (gray),
        .x           (x),
        .y           (y),
        .pixel_GS    (pixel_GS),
        .pixel_write (pixel_write),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (pixel_write === 1'b1) begin
            wr_cnt++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("write_xy_gs", {2'b0, x, y, pixel_GS},
                    {2'b0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_brush(input int bx, input int by, input int g);
        for (int dy = 0; dy < BR; dy++)
            for (int dx = 0; dx < BR; dx++)
                if (bx + dx < SW && by + dy < SH)
                    exp_q.push_back({11'(bx + dx), 11'(by + dy), 8'(g)});
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({11'(i % SW), 11'(i / SW), 8'h00});
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic pulse_paint(input int mx, input int my, input int g);
        mouse_x = 11'(mx);
        mouse_y = 11'(my);
        gray    = 8'(g);
        enable  = 1'b1;
        tick();
        enable  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_gs", pixel_GS, 0);
        chk("rst_pw", pixel_write, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_pw", pixel_write, 0);

        busy_cnt = 0;
        push_brush(100, 50, 8'h80);
        pulse_paint(100, 50, 8'h80);
        chk("first_write_latency", pixel_write, 1);
        drain("basic", 40);
        chk("basic_busy_cycles", busy_cnt, 16);
        chk("basic_after_pw", pixel_write, 0);

        busy_cnt = 0;
        push_brush(SW - 2, SH - 2, 8'hC3);
        pulse_paint(SW - 2, SH - 2, 8'hC3);
        drain("corner", 40);
        chk("corner_busy_cycles", busy_cnt, 16);

        wr_cnt  = 0;
        middle  = 1'b1;
        mouse_x = 11'd10;
        mouse_y = 11'd10;
        gray    = 8'h55;
        push_brush(10, 10, 8'h00);
        enable  = 1'b1;
        repeat (40) tick();
        chk("hold_one_burst", wr_cnt, 16);
        mouse_x = 11'd11;
        push_brush(11, 10, 8'h00);
        repeat (30) tick();
        enable = 1'b0;
        middle = 1'b0;
        drain("hold", 40);
        chk("hold_two_bursts", wr_cnt, 32);

        busy_cnt = 0;
        push_brush(20, 20, 8'h33);
        push_clear(SW * SH);
        pulse_paint(20, 20, 8'h33);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drain("paint_then_clear", SW * SH + 100);
        chk("clear_busy_cycles", busy_cnt, 16 + SW * SH);
        chk("clear_after_pw", pixel_write, 0);

        busy_cnt = 0;
        push_brush(20, 20, 8'h33);
        pulse_paint(20, 20, 8'h33);
        drain("repaint_after_clear", 40);
        chk("repaint_busy_cycles", busy_cnt, 16);

        wr_cnt = 0;
        push_clear(1000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        chk("abort_reached_1000", wr_cnt, 1000);
        reset_n = 1'b0;
        tick();
        chk("abort_pw", pixel_write, 0);
        chk("abort_busy", busy, 0);
        chk("abort_x", x, 0);
        tick();
        reset_n = 1'b1;
        snap = wr_cnt;
        repeat (20) tick();
        chk("abort_no_more_writes", wr_cnt, snap);
        chk("abort_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
